// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM arbiter (VGA burst reads, CPU single words).
// Owner/phase decode helpers keep the state-to-role mapping in one place.
package sdram_arb_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam int BLEN_W = 5;
  localparam int STAT_W = 32;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_VGA_ISSUE,
    ARB_VGA_WAIT,
    ARB_CPU_ISSUE,
    ARB_CPU_WAIT
  } arb_state_e;

  function automatic logic owner_is_vga(input arb_state_e s);
    return (s == ARB_VGA_ISSUE) || (s == ARB_VGA_WAIT);
  endfunction

  function automatic logic owner_is_cpu(input arb_state_e s);
    return (s == ARB_CPU_ISSUE) || (s == ARB_CPU_WAIT);
  endfunction

  function automatic logic in_issue(input arb_state_e s);
    return (s == ARB_VGA_ISSUE) || (s == ARB_CPU_ISSUE);
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Grants the single SDRAM controller port to the VGA burst reader or the CPU, VGA first with a
// CPU starvation limit. Define SDRAM_ARB_STATS_EN to add grant and CPU wait counters.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int VGA_BURST  = 16,
  parameter int STARVE_MAX = 64
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              vga_request,
  output logic              vga_ready,
  input  logic [ADDR_W-1:0] vga_address,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] vga_raddress,
  output logic              vga_complete,

  input  logic              cpu_request,
  output logic              cpu_ready,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [MASK_W-1:0] cpu_wmask,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_complete,

  output logic              sdram_request,
  input  logic              sdram_ready,
  output logic              sdram_write,
  output logic [BLEN_W-1:0] sdram_burst_len,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [DATA_W-1:0] sdram_wdata,
  output logic [MASK_W-1:0] sdram_wmask,
  input  logic              sdram_rvalid,
  input  logic [DATA_W-1:0] sdram_rdata,
  input  logic [ADDR_W-1:0] sdram_raddress,
  input  logic              sdram_complete
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_vga_grants,
  output logic [STAT_W-1:0] stat_cpu_grants,
  output logic [STAT_W-1:0] stat_cpu_wait
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [BLEN_W-1:0] VGA_BLEN   = BLEN_W'(VGA_BURST);
  localparam logic [BLEN_W-1:0] CPU_BLEN   = BLEN_W'(1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_vga_own;
  logic w_cpu_own;
  logic w_issue;
  logic w_starved;
  logic w_grant_cpu;

  assign w_vga_own   = owner_is_vga(r_state);
  assign w_cpu_own   = owner_is_cpu(r_state);
  assign w_issue     = in_issue(r_state);
  assign w_starved   = (r_starve_cnt == STARVE_LIM);
  assign w_grant_cpu = (r_state == ARB_IDLE) && (w_state_nxt == ARB_CPU_ISSUE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant is decided only from IDLE, so every transaction is followed by at least one IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (vga_request && !(cpu_request && w_starved)) begin
          w_state_nxt = ARB_VGA_ISSUE;
        end else if (cpu_request) begin
          w_state_nxt = ARB_CPU_ISSUE;
        end
      end
      ARB_VGA_ISSUE: begin
        if (sdram_complete || !vga_request) begin
          w_state_nxt = ARB_IDLE;
        end else if (sdram_ready) begin
          w_state_nxt = ARB_VGA_WAIT;
        end
      end
      ARB_VGA_WAIT: begin
        if (sdram_complete) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_CPU_ISSUE: begin
        if (sdram_complete || !cpu_request) begin
          w_state_nxt = ARB_IDLE;
        end else if (sdram_ready) begin
          w_state_nxt = ARB_CPU_WAIT;
        end
      end
      ARB_CPU_WAIT: begin
        if (sdram_complete) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Request side is driven only during issue; response side only to the current owner.
  always_comb begin
    sdram_request   = 1'b0;
    sdram_write     = 1'b0;
    sdram_burst_len = '0;
    sdram_address   = '0;
    sdram_wdata     = '0;
    sdram_wmask     = '0;
    vga_ready       = 1'b0;
    cpu_ready       = 1'b0;
    vga_rvalid      = 1'b0;
    vga_rdata       = '0;
    vga_raddress    = '0;
    vga_complete    = 1'b0;
    cpu_rvalid      = 1'b0;
    cpu_rdata       = '0;
    cpu_complete    = 1'b0;

    if (w_issue && w_vga_own) begin
      sdram_request   = vga_request;
      sdram_burst_len = VGA_BLEN;
      sdram_address   = vga_address;
      vga_ready       = sdram_ready;
    end
    if (w_issue && w_cpu_own) begin
      sdram_request   = cpu_request;
      sdram_write     = cpu_write;
      sdram_burst_len = CPU_BLEN;
      sdram_address   = cpu_address;
      sdram_wdata     = cpu_wdata;
      sdram_wmask     = cpu_wmask;
      cpu_ready       = sdram_ready;
    end

    if (w_vga_own) begin
      vga_rvalid   = sdram_rvalid;
      vga_rdata    = sdram_rdata;
      vga_raddress = sdram_raddress;
      vga_complete = sdram_complete;
    end
    if (w_cpu_own) begin
      cpu_rvalid   = sdram_rvalid;
      cpu_rdata    = sdram_rdata;
      cpu_complete = sdram_complete;
    end
  end

  // Cycles a waiting CPU has been passed over; reaching the limit flips the next tie to the CPU.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_cpu) begin
      r_starve_cnt <= '0;
    end else if (cpu_request && !w_cpu_own && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_ONE;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic              w_grant_vga;
  logic [STAT_W-1:0] r_stat_vga_grants;
  logic [STAT_W-1:0] r_stat_cpu_grants;
  logic [STAT_W-1:0] r_stat_cpu_wait;

  assign w_grant_vga = (r_state == ARB_IDLE) && (w_state_nxt == ARB_VGA_ISSUE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stat_vga_grants <= '0;
      r_stat_cpu_grants <= '0;
      r_stat_cpu_wait   <= '0;
    end else begin
      if (w_grant_vga) begin
        r_stat_vga_grants <= r_stat_vga_grants + STAT_W'(1);
      end
      if (w_grant_cpu) begin
        r_stat_cpu_grants <= r_stat_cpu_grants + STAT_W'(1);
      end
      if (cpu_request && !cpu_ready) begin
        r_stat_cpu_wait <= r_stat_cpu_wait + STAT_W'(1);
      end
    end
  end

  assign stat_vga_grants = r_stat_vga_grants;
  assign stat_cpu_grants = r_stat_cpu_grants;
  assign stat_cpu_wait   = r_stat_cpu_wait;
`endif

`ifndef SYNTHESIS
  // Read data or completion with no owner means the controller and arbiter disagree.
  always_ff @(posedge clock) begin
    if (reset_n && (r_state == ARB_IDLE)) begin
      assert (!sdram_rvalid && !sdram_complete);
    end
  end
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: the bench plays the SDRAM controller and both requesters.
// Build with SDRAM_ARB_STATS_EN defined to include the statistics scenario.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        vga_request;
  logic        vga_ready;
  logic [25:0] vga_address;
  logic        vga_rvalid;
  logic [31:0] vga_rdata;
  logic [25:0] vga_raddress;
  logic        vga_complete;
  logic        cpu_request;
  logic        cpu_ready;
  logic        cpu_write;
  logic [25:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_complete;
  logic        sdram_request;
  logic        sdram_ready;
  logic        sdram_write;
  logic [4:0]  sdram_burst_len;
  logic [25:0] sdram_address;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_wmask;
  logic        sdram_rvalid;
  logic [31:0] sdram_rdata;
  logic [25:0] sdram_raddress;
  logic        sdram_complete;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] stat_vga_grants;
  logic [31:0] stat_cpu_grants;
  logic [31:0] stat_cpu_wait;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [164:0] all_outs;
  assign all_outs = {vga_ready, vga_rvalid, vga_rdata, vga_raddress, vga_complete,
                     cpu_ready, cpu_rvalid, cpu_rdata, cpu_complete,
                     sdram_request, sdram_write, sdram_burst_len, sdram_address,
                     sdram_wdata, sdram_wmask};

  always #5 clock = ~clock;

  sdram_arbiter #(.VGA_BURST(16), .STARVE_MAX(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .vga_request(vga_request), .vga_ready(vga_ready), .vga_address(vga_address),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .vga_raddress(vga_raddress),
    .vga_complete(vga_complete),
    .cpu_request(cpu_request), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_complete(cpu_complete),
    .sdram_request(sdram_request), .sdram_ready(sdram_ready), .sdram_write(sdram_write),
    .sdram_burst_len(sdram_burst_len), .sdram_address(sdram_address),
    .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask), .sdram_rvalid(sdram_rvalid),
    .sdram_rdata(sdram_rdata), .sdram_raddress(sdram_raddress),
    .sdram_complete(sdram_complete)
`ifdef SDRAM_ARB_STATS_EN
    , .stat_vga_grants(stat_vga_grants), .stat_cpu_grants(stat_cpu_grants),
    .stat_cpu_wait(stat_cpu_wait)
`endif
  );

  task automatic test_reset();
    reset_n = 1'b0;
    vga_request = 1'b1;
    cpu_request = 1'b1;
    sdram_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got %h want 0", all_outs);
    end
    vga_request = 1'b0;
    cpu_request = 1'b0;
    sdram_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL idle_outs: got %h want 0", all_outs);
    end
  endtask

  task automatic test_vga_alone();
    logic exp_rdy;
    @(negedge clock);
    vga_request = 1'b1;
    vga_address = 26'h100;
    #1;
    n_vec++;
    if (sdram_request !== 1'b0) begin
      n_err++;
      $display("FAIL vga_idle_req: got %b want 0", sdram_request);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      sdram_ready = (c == 2);
      exp_rdy = (c == 2);
      #1;
      n_vec++;
      if ({sdram_request, sdram_write, sdram_burst_len, sdram_address} !==
          {1'b1, 1'b0, 5'd16, 26'h100}) begin
        n_err++;
        $display("FAIL vga_issue: got %b %b %0d %h want 1 0 16 100",
                 sdram_request, sdram_write, sdram_burst_len, sdram_address);
      end
      n_vec++;
      if ({vga_ready, cpu_ready} !== {exp_rdy, 1'b0}) begin
        n_err++;
        $display("FAIL vga_ready: got %b%b want %b0", vga_ready, cpu_ready, exp_rdy);
      end
    end
    @(negedge clock);
    sdram_ready = 1'b0;
    vga_request = 1'b0;
    #1;
    n_vec++;
    if ({sdram_request, vga_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL vga_wait_req: got %b%b want 00", sdram_request, vga_ready);
    end
    for (int w = 0; w < 16; w++) begin
      @(negedge clock);
      sdram_rvalid   = 1'b1;
      sdram_rdata    = 32'hA500_0000 + 32'(w);
      sdram_raddress = 26'h100 + 26'(4 * w);
      #1;
      n_vec++;
      if ({vga_rvalid, vga_rdata, vga_raddress, cpu_rvalid} !==
          {1'b1, 32'hA500_0000 + 32'(w), 26'h100 + 26'(4 * w), 1'b0}) begin
        n_err++;
        $display("FAIL vga_word%0d: got %b %h %h cpu_rvalid=%b", w,
                 vga_rvalid, vga_rdata, vga_raddress, cpu_rvalid);
      end
    end
    @(negedge clock);
    sdram_rvalid   = 1'b0;
    sdram_complete = 1'b1;
    #1;
    n_vec++;
    if ({vga_complete, cpu_complete, vga_rvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL vga_complete: got %b%b%b want 100", vga_complete, cpu_complete, vga_rvalid);
    end
    @(negedge clock);
    sdram_complete = 1'b0;
    #1;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL vga_back_idle: got %h want 0", all_outs);
    end
  endtask

  task automatic test_cpu_write();
    @(negedge clock);
    cpu_request = 1'b1;
    cpu_write   = 1'b1;
    cpu_address = 26'h2000;
    cpu_wdata   = 32'hDEAD_BEEF;
    cpu_wmask   = 4'b0011;
    #1;
    n_vec++;
    if ({cpu_ready, sdram_request} !== 2'b00) begin
      n_err++;
      $display("FAIL cpu_idle: got %b%b want 00", cpu_ready, sdram_request);
    end
    @(negedge clock);
    sdram_ready = 1'b1;
    #1;
    n_vec++;
    if ({sdram_request, sdram_write, sdram_burst_len, sdram_address, sdram_wdata, sdram_wmask} !==
        {1'b1, 1'b1, 5'd1, 26'h2000, 32'hDEAD_BEEF, 4'b0011}) begin
      n_err++;
      $display("FAIL cpu_wr_bus: got %b %b %0d %h %h %b want 1 1 1 2000 deadbeef 0011",
               sdram_request, sdram_write, sdram_burst_len, sdram_address, sdram_wdata, sdram_wmask);
    end
    n_vec++;
    if ({cpu_ready, vga_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL cpu_wr_ready: got %b%b want 10", cpu_ready, vga_ready);
    end
    @(negedge clock);
    sdram_ready = 1'b0;
    cpu_request = 1'b0;
    cpu_write   = 1'b0;
    #1;
    n_vec++;
    if ({sdram_request, cpu_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL cpu_wr_wait: got %b%b want 00", sdram_request, cpu_ready);
    end
    @(negedge clock);
    sdram_complete = 1'b1;
    #1;
    n_vec++;
    if ({cpu_complete, vga_complete, vga_rvalid, cpu_rvalid} !== 4'b1000) begin
      n_err++;
      $display("FAIL cpu_wr_cpl: got %b%b%b%b want 1000",
               cpu_complete, vga_complete, vga_rvalid, cpu_rvalid);
    end
    @(negedge clock);
    sdram_complete = 1'b0;
    #1;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL cpu_back_idle: got %h want 0", all_outs);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clock);
    vga_request = 1'b1;
    vga_address = 26'h400;
    cpu_request = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = 26'h3000;
    @(negedge clock);
    sdram_ready = 1'b1;
    #1;
    n_vec++;
    if ({sdram_burst_len, sdram_address, sdram_write, vga_ready, cpu_ready} !==
        {5'd16, 26'h400, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL tie_vga_first: got %0d %h %b %b%b want 16 400 0 10",
               sdram_burst_len, sdram_address, sdram_write, vga_ready, cpu_ready);
    end
    @(negedge clock);
    sdram_ready = 1'b0;
    vga_request = 1'b0;
    @(negedge clock);
    sdram_rvalid   = 1'b1;
    sdram_rdata    = 32'h1111_2222;
    sdram_raddress = 26'h400;
    #1;
    n_vec++;
    if ({vga_rvalid, cpu_rvalid, cpu_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL tie_route: got %b %b %h want 1 0 0", vga_rvalid, cpu_rvalid, cpu_rdata);
    end
    @(negedge clock);
    sdram_rvalid   = 1'b0;
    sdram_complete = 1'b1;
    #1;
    n_vec++;
    if ({vga_complete, cpu_complete} !== 2'b10) begin
      n_err++;
      $display("FAIL tie_vga_cpl: got %b%b want 10", vga_complete, cpu_complete);
    end
    @(negedge clock);
    sdram_complete = 1'b0;
    #1;
    n_vec++;
    if ({sdram_request, cpu_ready, vga_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL tie_idle_gap: got %b%b%b want 000", sdram_request, cpu_ready, vga_ready);
    end
    @(negedge clock);
    sdram_ready = 1'b1;
    #1;
    n_vec++;
    if ({sdram_request, sdram_burst_len, sdram_address, sdram_write, cpu_ready, vga_ready} !==
        {1'b1, 5'd1, 26'h3000, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL tie_cpu_second: got %b %0d %h %b %b%b want 1 1 3000 0 10",
               sdram_request, sdram_burst_len, sdram_address, sdram_write, cpu_ready, vga_ready);
    end
    @(negedge clock);
    sdram_ready = 1'b0;
    cpu_request = 1'b0;
    @(negedge clock);
    sdram_rvalid   = 1'b1;
    sdram_rdata    = 32'hCAFE_F00D;
    sdram_raddress = 26'h3000;
    #1;
    n_vec++;
    if ({cpu_rvalid, cpu_rdata, vga_rvalid} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
      n_err++;
      $display("FAIL tie_cpu_rd: got %b %h %b want 1 cafef00d 0", cpu_rvalid, cpu_rdata, vga_rvalid);
    end
    @(negedge clock);
    sdram_rvalid   = 1'b0;
    sdram_complete = 1'b1;
    #1;
    n_vec++;
    if ({cpu_complete, vga_complete} !== 2'b10) begin
      n_err++;
      $display("FAIL tie_cpu_cpl: got %b%b want 10", cpu_complete, vga_complete);
    end
    @(negedge clock);
    sdram_complete = 1'b0;
  endtask

  task automatic test_starvation();
    int   n_vga;
    logic got_cpu;
    logic found;
    n_vga   = 0;
    got_cpu = 1'b0;
    @(negedge clock);
    vga_request = 1'b1;
    vga_address = 26'h800;
    cpu_request = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = 26'h5000;
    for (int t = 0; t < 12 && !got_cpu; t++) begin
      found = 1'b0;
      for (int w = 0; w < 5 && !found; w++) begin
        @(negedge clock);
        #1;
        if (sdram_request) found = 1'b1;
      end
      if (!found) break;
      sdram_ready = 1'b1;
      #1;
      if (sdram_burst_len == 5'd1) begin
        got_cpu = 1'b1;
        n_vec++;
        if ({cpu_ready, vga_ready, sdram_address} !== {1'b1, 1'b0, 26'h5000}) begin
          n_err++;
          $display("FAIL starve_cpu_issue: got %b%b %h want 10 5000",
                   cpu_ready, vga_ready, sdram_address);
        end
      end else begin
        n_vga++;
      end
      @(negedge clock);
      sdram_ready    = 1'b0;
      sdram_complete = 1'b1;
      if (got_cpu) cpu_request = 1'b0;
      @(negedge clock);
      sdram_complete = 1'b0;
    end
    n_vec++;
    if (!got_cpu) begin
      n_err++;
      $display("FAIL starve_cpu_grant: got no cpu grant want grant after 3 vga");
    end
    n_vec++;
    if (n_vga !== 3) begin
      n_err++;
      $display("FAIL starve_vga_count: got %0d want 3", n_vga);
    end
    // Counter must have cleared: a fresh tie goes back to VGA.
    cpu_request = 1'b1;
    @(negedge clock);
    #1;
    n_vec++;
    if ({sdram_request, sdram_burst_len} !== {1'b1, 5'd16}) begin
      n_err++;
      $display("FAIL starve_cleared: got %b %0d want 1 16", sdram_request, sdram_burst_len);
    end
    sdram_ready = 1'b1;
    @(negedge clock);
    sdram_ready    = 1'b0;
    vga_request    = 1'b0;
    cpu_request    = 1'b0;
    sdram_complete = 1'b1;
    @(negedge clock);
    sdram_complete = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clock);
    vga_request = 1'b1;
    vga_address = 26'hA00;
    @(negedge clock);
    sdram_ready = 1'b1;
    @(negedge clock);
    sdram_ready = 1'b0;
    vga_request = 1'b0;
    for (int w = 0; w < 7; w++) begin
      @(negedge clock);
      sdram_rvalid   = 1'b1;
      sdram_rdata    = 32'h7000_0000 + 32'(w);
      sdram_raddress = 26'hA00 + 26'(4 * w);
    end
    @(negedge clock);
    sdram_rdata    = 32'h7000_0007;
    sdram_raddress = 26'hA1C;
    reset_n        = 1'b0;
    #1;
    n_vec++;
    if ({vga_rvalid, vga_rdata} !== {1'b1, 32'h7000_0007}) begin
      n_err++;
      $display("FAIL rst_word7: got %b %h want 1 70000007", vga_rvalid, vga_rdata);
    end
    @(negedge clock);
    #1;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL rst_abandon: got %h want 0", all_outs);
    end
    @(negedge clock);
    sdram_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      n_vec++;
      if (all_outs !== '0) begin
        n_err++;
        $display("FAIL rst_hold%0d: got %h want 0", c, all_outs);
      end
    end
    @(negedge clock);
    reset_n     = 1'b1;
    cpu_request = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = 26'h6000;
    @(negedge clock);
    sdram_ready = 1'b1;
    #1;
    n_vec++;
    if ({cpu_ready, sdram_address, sdram_burst_len} !== {1'b1, 26'h6000, 5'd1}) begin
      n_err++;
      $display("FAIL rst_cpu_issue: got %b %h %0d want 1 6000 1",
               cpu_ready, sdram_address, sdram_burst_len);
    end
    @(negedge clock);
    sdram_ready = 1'b0;
    cpu_request = 1'b0;
    @(negedge clock);
    sdram_rvalid = 1'b1;
    sdram_rdata  = 32'h0BAD_C0DE;
    #1;
    n_vec++;
    if ({cpu_rvalid, cpu_rdata, vga_rvalid} !== {1'b1, 32'h0BAD_C0DE, 1'b0}) begin
      n_err++;
      $display("FAIL rst_cpu_rd: got %b %h %b want 1 0badc0de 0", cpu_rvalid, cpu_rdata, vga_rvalid);
    end
    @(negedge clock);
    sdram_rvalid   = 1'b0;
    sdram_complete = 1'b1;
    #1;
    n_vec++;
    if (cpu_complete !== 1'b1) begin
      n_err++;
      $display("FAIL rst_cpu_cpl: got %b want 1", cpu_complete);
    end
    @(negedge clock);
    sdram_complete = 1'b0;
  endtask

`ifdef SDRAM_ARB_STATS_EN
  task automatic vga_txn(input logic [25:0] addr);
    @(negedge clock);
    vga_request = 1'b1;
    vga_address = addr;
    @(negedge clock);
    sdram_ready = 1'b1;
    @(negedge clock);
    sdram_ready    = 1'b0;
    vga_request    = 1'b0;
    sdram_complete = 1'b1;
    @(negedge clock);
    sdram_complete = 1'b0;
  endtask

  task automatic cpu_txn(input logic [25:0] addr);
    @(negedge clock);
    cpu_request = 1'b1;
    cpu_write   = 1'b1;
    cpu_address = addr;
    @(negedge clock);
    sdram_ready = 1'b1;
    @(negedge clock);
    sdram_ready    = 1'b0;
    cpu_request    = 1'b0;
    cpu_write      = 1'b0;
    sdram_complete = 1'b1;
    @(negedge clock);
    sdram_complete = 1'b0;
  endtask

  task automatic test_stats();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    vga_txn(26'h1000);
    cpu_txn(26'h1100);
    vga_txn(26'h1200);
    vga_txn(26'h1300);
    cpu_txn(26'h1400);
    #1;
    n_vec++;
    if ({stat_vga_grants, stat_cpu_grants, stat_cpu_wait} !== {32'd3, 32'd2, 32'd2}) begin
      n_err++;
      $display("FAIL stats: got vga=%0d cpu=%0d wait=%0d want 3 2 2",
               stat_vga_grants, stat_cpu_grants, stat_cpu_wait);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    vga_request    = 1'b0;
    vga_address    = '0;
    cpu_request    = 1'b0;
    cpu_write      = 1'b0;
    cpu_address    = '0;
    cpu_wdata      = '0;
    cpu_wmask      = '0;
    sdram_ready    = 1'b0;
    sdram_rvalid   = 1'b0;
    sdram_rdata    = '0;
    sdram_raddress = '0;
    sdram_complete = 1'b0;

    test_reset();
    test_vga_alone();
    test_cpu_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_burst();
`ifdef SDRAM_ARB_STATS_EN
    test_stats();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
